// File: rtl/bifrost_pkg.sv
// bifrost_pkg: shared constants for the Bifrost MMU and the downstream
// address decoder. Holds the register window layout, CTRL bit positions,
// the frame width and the I/O page, and a register-offset decode helper.
package bifrost_pkg;

    localparam int unsigned FRAME_W = 7;
    localparam logic [3:0]  IO_PAGE = 4'hD;

    localparam logic [15:0] WIN_BASE   = 16'hDE00;
    localparam logic [7:0]  WIN_SIZE   = 8'h30;
    localparam logic [7:0]  STAGE_OFF  = 8'h00;
    localparam logic [7:0]  CTRL_OFF   = 8'h10;
    localparam logic [7:0]  COMMIT_OFF = 8'h11;
    localparam logic [7:0]  ACTIVE_OFF = 8'h20;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_PENDING_BIT = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STAGE,
        REG_CTRL,
        REG_COMMIT,
        REG_ACTIVE
    } reg_kind_e;

    // Classifies a window offset; offsets outside any register map to REG_NONE.
    function automatic reg_kind_e decode_reg(input logic [7:0] off);
        reg_kind_e kind;
        kind = REG_NONE;
        if (off[7:4] == STAGE_OFF[7:4])       kind = REG_STAGE;
        else if (off == CTRL_OFF)             kind = REG_CTRL;
        else if (off == COMMIT_OFF)           kind = REG_COMMIT;
        else if (off[7:4] == ACTIVE_OFF[7:4]) kind = REG_ACTIVE;
        return kind;
    endfunction

endpackage

// File: rtl/bifrost_mmu_commit_timer.sv
// bifrost_mmu_commit_timer: delayed-commit countdown.
//   clock, reset_b : clock, async active-low reset
//   load, value    : restart the countdown with value (wins over expiry)
//   pending        : countdown in progress
//   fire           : combinational; high on the edge the copy must happen
module bifrost_mmu_commit_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             pending,
    output logic             fire
);

    logic [CNT_W-1:0] count;

    // A reload on the would-be expiry edge suppresses the copy.
    assign fire = pending && (count == '0) && !load;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (load) begin
            count   <= value;
            pending <= 1'b1;
        end else if (fire) begin
            pending <= 1'b0;
        end else if (pending) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bifrost_mmu.sv
// bifrost_mmu: 6502 CPU address -> physical address translation with 16
// page registers and a delayed atomic commit from STAGE to ACTIVE.
//   clock, reset_b : clock, async active-low reset
//   cpu_addr, rw   : CPU address bus, 1 = read
//   data_in        : CPU write data
//   addr           : translated physical address (combinational)
//   data_out       : register read data (combinational)
//   data_oe        : register window read in progress
//   pending        : commit countdown in progress
module bifrost_mmu #(
    parameter int unsigned FRAME_W = bifrost_pkg::FRAME_W,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clock,
    input  logic                reset_b,
    input  logic [15:0]         cpu_addr,
    input  logic                rw,
    input  logic [7:0]          data_in,
    output logic [FRAME_W+11:0] addr,
    output logic [7:0]          data_out,
    output logic                data_oe,
    output logic                pending
);

    import bifrost_pkg::*;

    logic [FRAME_W-1:0] stage  [16];
    logic [FRAME_W-1:0] active [16];
    logic               enable;
    logic               fire;
    logic               in_win;
    logic               wr;
    logic [3:0]         page;
    logic [3:0]         idx;
    logic [FRAME_W-1:0] frame;
    reg_kind_e          kind;

    assign page   = cpu_addr[15:12];
    assign idx    = cpu_addr[3:0];
    assign in_win = (cpu_addr[15:8] == WIN_BASE[15:8]) && (cpu_addr[7:0] < WIN_SIZE);
    assign kind   = decode_reg(cpu_addr[7:0]);
    assign wr     = in_win && !rw;
    assign data_oe = in_win && rw;

    bifrost_mmu_commit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_b (reset_b),
        .load    (wr && (kind == REG_COMMIT)),
        .value   (CNT_W'(data_in)),
        .pending (pending),
        .fire    (fire)
    );

    // STAGE is read before its own write in the same edge, so the copy
    // always takes the pre-write value.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int unsigned i = 0; i < 16; i++) begin
                stage[i]  <= FRAME_W'(i);
                active[i] <= FRAME_W'(i);
            end
            enable <= 1'b0;
        end else begin
            if (fire) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    active[i] <= stage[i];
                end
            end
            if (wr && (kind == REG_STAGE)) begin
                stage[idx] <= data_in[FRAME_W-1:0];
            end
            if (wr && (kind == REG_CTRL)) begin
                enable <= data_in[CTRL_ENABLE_BIT];
            end
        end
    end

    always_comb begin
        frame = FRAME_W'(page);
        if (page == IO_PAGE) begin
            frame = FRAME_W'(IO_PAGE);
        end else if (enable) begin
            frame = active[page];
        end
    end

    assign addr = {frame, cpu_addr[11:0]};

    always_comb begin
        data_out = '0;
        if (data_oe) begin
            case (kind)
                REG_STAGE:  data_out = 8'(stage[idx]);
                REG_ACTIVE: data_out = 8'(active[idx]);
                REG_CTRL: begin
                    data_out[CTRL_ENABLE_BIT]  = enable;
                    data_out[CTRL_PENDING_BIT] = pending;
                end
                default:    data_out = '0;
            endcase
        end
    end

endmodule
